// File: rtl/hazard_scoreboard_if.sv
// D-stage hazard interface: the decoded D-stage instruction fields and
// the stall / forward-select results returned to the pipeline.
// d_valid qualifies every other D field; there is no ready, and the unit
// answers combinationally in the same cycle the fields are presented.
interface hazard_scoreboard_if #(
  parameter int ADDR_W = 5,
  parameter int STAGES = 3,
  parameter int T_W    = 2
);
  localparam int FW_W = $clog2(STAGES + 1);

  logic              d_valid;
  logic [ADDR_W-1:0] d_a1;
  logic [ADDR_W-1:0] d_a2;
  logic [T_W-1:0]    d_tuse1;
  logic [T_W-1:0]    d_tuse2;
  logic [ADDR_W-1:0] d_a3;
  logic [T_W-1:0]    d_tnew;
  logic              flush;
  logic              stall;
  logic [FW_W-1:0]   d_fwd1_sel;
  logic [FW_W-1:0]   d_fwd2_sel;
  logic [FW_W-1:0]   e_fwd1_sel;
  logic [FW_W-1:0]   e_fwd2_sel;

  // Pipeline side: presents the D instruction, consumes the decisions.
  modport master (
    output d_valid, d_a1, d_a2, d_tuse1, d_tuse2, d_a3, d_tnew, flush,
    input  stall, d_fwd1_sel, d_fwd2_sel, e_fwd1_sel, e_fwd2_sel
  );

  // Hazard unit side.
  modport slave (
    input  d_valid, d_a1, d_a2, d_tuse1, d_tuse2, d_a3, d_tnew, flush,
    output stall, d_fwd1_sel, d_fwd2_sel, e_fwd1_sel, e_fwd2_sel
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// Hazard / forwarding unit beside the D stage of the pipelined MIPS core.
// A shift-register scoreboard follows every in-flight writer through the
// stages after D (entry 0 = E, 1 = M, 2 = W). Each entry carries its
// destination and a countdown (tnew) to the cycle its result becomes
// forwardable. The D instruction is checked against the youngest matching
// writer; a writer that is not ready in time stalls D and bubbles E.
// Forward select encoding: 0 = register file, k+1 = scoreboard entry k.
module hazard_scoreboard #(
  parameter int ADDR_W = 5,
  parameter int STAGES = 3,
  parameter int T_W    = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  hazard_scoreboard_if.slave   hz
);

  localparam int FW_W = $clog2(STAGES + 1);

  // Scoreboard entries.
  logic [STAGES-1:0] r_valid;
  logic [ADDR_W-1:0] r_a3   [STAGES];
  logic [T_W-1:0]    r_tnew [STAGES];
  // Source addresses of the instruction currently in E (entry 0 only).
  logic [ADDR_W-1:0] r_src1;
  logic [ADDR_W-1:0] r_src2;

  // Youngest-match results for the D-stage reads.
  logic              w_d_hit1;
  logic [FW_W-1:0]   w_d_idx1;
  logic [T_W-1:0]    w_d_tn1;
  logic              w_d_hit2;
  logic [FW_W-1:0]   w_d_idx2;
  logic [T_W-1:0]    w_d_tn2;

  // Youngest-match results for the E-stage reads.
  logic              w_e_hit1;
  logic [FW_W-1:0]   w_e_idx1;
  logic [T_W-1:0]    w_e_tn1;
  logic              w_e_hit2;
  logic [FW_W-1:0]   w_e_idx2;
  logic [T_W-1:0]    w_e_tn2;

  logic              w_d_rd1;
  logic              w_d_rd2;
  logic              w_stall1;
  logic              w_stall2;
  logic              w_stall;
  logic [FW_W-1:0]   w_d_sel1;
  logic [FW_W-1:0]   w_d_sel2;
  logic [FW_W-1:0]   w_e_sel1;
  logic [FW_W-1:0]   w_e_sel2;

  // Youngest live writer for each D source: scan oldest to youngest so the
  // lowest matching index is the one that survives.
  always_comb begin
    w_d_hit1 = 1'b0;
    w_d_idx1 = '0;
    w_d_tn1  = '0;
    w_d_hit2 = 1'b0;
    w_d_idx2 = '0;
    w_d_tn2  = '0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      if (r_valid[k] && (r_a3[k] == hz.d_a1) && (hz.d_a1 != '0)) begin
        w_d_hit1 = 1'b1;
        w_d_idx1 = FW_W'(k);
        w_d_tn1  = r_tnew[k];
      end
      if (r_valid[k] && (r_a3[k] == hz.d_a2) && (hz.d_a2 != '0)) begin
        w_d_hit2 = 1'b1;
        w_d_idx2 = FW_W'(k);
        w_d_tn2  = r_tnew[k];
      end
    end
  end

  // Youngest live writer for each E source, searched behind E only.
  always_comb begin
    w_e_hit1 = 1'b0;
    w_e_idx1 = '0;
    w_e_tn1  = '0;
    w_e_hit2 = 1'b0;
    w_e_idx2 = '0;
    w_e_tn2  = '0;
    for (int k = STAGES - 1; k >= 1; k--) begin
      if (r_valid[k] && (r_a3[k] == r_src1) && (r_src1 != '0)) begin
        w_e_hit1 = 1'b1;
        w_e_idx1 = FW_W'(k);
        w_e_tn1  = r_tnew[k];
      end
      if (r_valid[k] && (r_a3[k] == r_src2) && (r_src2 != '0)) begin
        w_e_hit2 = 1'b1;
        w_e_idx2 = FW_W'(k);
        w_e_tn2  = r_tnew[k];
      end
    end
  end

  // Stall and forward decisions. A younger writer that is not ready hides
  // any older ready one, so a stale value is never forwarded.
  always_comb begin
    w_d_rd1  = hz.d_valid && (hz.d_a1 != '0);
    w_d_rd2  = hz.d_valid && (hz.d_a2 != '0);
    w_stall1 = w_d_rd1 && w_d_hit1 && (w_d_tn1 > hz.d_tuse1);
    w_stall2 = w_d_rd2 && w_d_hit2 && (w_d_tn2 > hz.d_tuse2);
    w_stall  = w_stall1 || w_stall2;
    w_d_sel1 = '0;
    w_d_sel2 = '0;
    w_e_sel1 = '0;
    w_e_sel2 = '0;
    if (w_d_rd1 && w_d_hit1 && (w_d_tn1 == '0)) w_d_sel1 = w_d_idx1 + FW_W'(1);
    if (w_d_rd2 && w_d_hit2 && (w_d_tn2 == '0)) w_d_sel2 = w_d_idx2 + FW_W'(1);
    if (w_e_hit1 && (w_e_tn1 == '0)) w_e_sel1 = w_e_idx1 + FW_W'(1);
    if (w_e_hit2 && (w_e_tn2 == '0)) w_e_sel2 = w_e_idx2 + FW_W'(1);
  end

  assign hz.stall      = w_stall;
  assign hz.d_fwd1_sel = w_d_sel1;
  assign hz.d_fwd2_sel = w_d_sel2;
  assign hz.e_fwd1_sel = w_e_sel1;
  assign hz.e_fwd2_sel = w_e_sel2;

  // Advance the scoreboard: shift older entries down with a saturating
  // tnew countdown, and load E from D (or a bubble while stalled).
  // Flush and reset empty every entry, overriding any pending stall.
  always_ff @(posedge clk) begin
    if (reset || hz.flush) begin
      r_valid <= '0;
      for (int k = 0; k < STAGES; k++) begin
        r_a3[k]   <= '0;
        r_tnew[k] <= '0;
      end
      r_src1 <= '0;
      r_src2 <= '0;
    end else begin
      for (int k = 1; k < STAGES; k++) begin
        r_valid[k] <= r_valid[k-1];
        r_a3[k]    <= r_a3[k-1];
        r_tnew[k]  <= (r_tnew[k-1] == '0) ? '0 : (r_tnew[k-1] - T_W'(1));
      end
      if (w_stall) begin
        r_valid[0] <= 1'b0;
        r_a3[0]    <= '0;
        r_tnew[0]  <= '0;
        r_src1     <= '0;
        r_src2     <= '0;
      end else begin
        r_valid[0] <= hz.d_valid && (hz.d_a3 != '0);
        r_a3[0]    <= hz.d_a3;
        r_tnew[0]  <= hz.d_tnew;
        r_src1     <= hz.d_a1;
        r_src2     <= hz.d_a2;
      end
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: load-use stall, ALU forwarding,
// youngest-writer priority, $0 immunity, flush and reset behaviour.
module tb_hazard_scoreboard;
  localparam int ADDR_W = 5;
  localparam int STAGES = 3;
  localparam int T_W    = 2;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;

  hazard_scoreboard_if #(.ADDR_W(ADDR_W), .STAGES(STAGES), .T_W(T_W)) hz ();

  hazard_scoreboard #(.ADDR_W(ADDR_W), .STAGES(STAGES), .T_W(T_W)) dut (
    .clk   (clk),
    .reset (reset),
    .hz    (hz)
  );

  // Clock: 10 time-unit period.
  always #5 clk = ~clk;

  // Single comparison point.
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // All five outputs against expected values.
  task automatic check_all(input string tag, input logic st, input logic [1:0] d1,
                           input logic [1:0] d2, input logic [1:0] e1, input logic [1:0] e2);
    check({tag, "_stall"}, 32'(hz.stall), 32'(st));
    check({tag, "_dfwd1"}, 32'(hz.d_fwd1_sel), 32'(d1));
    check({tag, "_dfwd2"}, 32'(hz.d_fwd2_sel), 32'(d2));
    check({tag, "_efwd1"}, 32'(hz.e_fwd1_sel), 32'(e1));
    check({tag, "_efwd2"}, 32'(hz.e_fwd2_sel), 32'(e2));
  endtask

  // Advance one rising edge, then wait until outputs have settled.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Present a D-stage instruction.
  task automatic drive_d(input logic v, input logic [4:0] a1, input logic [1:0] tu1,
                         input logic [4:0] a2, input logic [1:0] tu2,
                         input logic [4:0] a3, input logic [1:0] tn);
    hz.d_valid = v;
    hz.d_a1    = a1;
    hz.d_tuse1 = tu1;
    hz.d_a2    = a2;
    hz.d_tuse2 = tu2;
    hz.d_a3    = a3;
    hz.d_tnew  = tn;
    #1;
  endtask

  // Empty the scoreboard with a one-cycle flush and an idle D.
  task automatic do_flush();
    drive_d(1'b0, 5'd0, 2'd0, 5'd0, 2'd0, 5'd0, 2'd0);
    hz.flush = 1'b1;
    step();
    hz.flush = 1'b0;
    #1;
  endtask

  initial begin
    // Reset held two cycles while D reads r8.
    reset    = 1'b1;
    hz.flush = 1'b0;
    drive_d(1'b1, 5'd8, 2'd0, 5'd0, 2'd0, 5'd0, 2'd0);
    step();
    check_all("rst_c1", 1'b0, 2'd0, 2'd0, 2'd0, 2'd0);
    step();
    check_all("rst_c2", 1'b0, 2'd0, 2'd0, 2'd0, 2'd0);
    reset = 1'b0;
    #1;
    check_all("post_rst", 1'b0, 2'd0, 2'd0, 2'd0, 2'd0);

    // Load-use: lw r8 (tnew 2), then addu reading r8 at Tuse 1.
    do_flush();
    drive_d(1'b1, 5'd0, 2'd0, 5'd0, 2'd0, 5'd8, 2'd2);
    step();
    drive_d(1'b1, 5'd8, 2'd1, 5'd0, 2'd0, 5'd11, 2'd1);
    check_all("lu_c1", 1'b1, 2'd0, 2'd0, 2'd0, 2'd0);
    step();
    check_all("lu_c2", 1'b0, 2'd0, 2'd0, 2'd0, 2'd0);
    step();
    check_all("lu_c3", 1'b0, 2'd3, 2'd0, 2'd3, 2'd0);

    // ALU back-to-back: addu r9 (tnew 1), consumer reads r9 on source 2.
    do_flush();
    drive_d(1'b1, 5'd0, 2'd0, 5'd0, 2'd0, 5'd9, 2'd1);
    step();
    drive_d(1'b1, 5'd0, 2'd0, 5'd9, 2'd1, 5'd0, 2'd0);
    check_all("alu_d", 1'b0, 2'd0, 2'd0, 2'd0, 2'd0);
    step();
    check_all("alu_e", 1'b0, 2'd0, 2'd2, 2'd0, 2'd2);

    // Youngest writer wins even when it is not yet ready.
    do_flush();
    drive_d(1'b1, 5'd0, 2'd0, 5'd0, 2'd0, 5'd10, 2'd1);
    step();
    drive_d(1'b1, 5'd0, 2'd0, 5'd0, 2'd0, 5'd10, 2'd2);
    step();
    drive_d(1'b1, 5'd10, 2'd0, 5'd0, 2'd0, 5'd0, 2'd0);
    check_all("yw_c1", 1'b1, 2'd0, 2'd0, 2'd0, 2'd0);
    step();
    check_all("yw_c2", 1'b1, 2'd0, 2'd0, 2'd0, 2'd0);
    step();
    check_all("yw_c3", 1'b0, 2'd3, 2'd0, 2'd0, 2'd0);

    // $0 is never tracked or forwarded.
    do_flush();
    drive_d(1'b1, 5'd0, 2'd0, 5'd0, 2'd0, 5'd0, 2'd3);
    step();
    drive_d(1'b1, 5'd0, 2'd0, 5'd0, 2'd0, 5'd0, 2'd0);
    check_all("zero_d", 1'b0, 2'd0, 2'd0, 2'd0, 2'd0);
    step();
    check_all("zero_e", 1'b0, 2'd0, 2'd0, 2'd0, 2'd0);

    // tnew 0 producer forwards straight from E; d_valid gates the check.
    do_flush();
    drive_d(1'b1, 5'd0, 2'd0, 5'd0, 2'd0, 5'd12, 2'd0);
    step();
    drive_d(1'b1, 5'd12, 2'd0, 5'd12, 2'd0, 5'd0, 2'd0);
    check_all("e0_fwd", 1'b0, 2'd1, 2'd1, 2'd0, 2'd0);
    drive_d(1'b0, 5'd12, 2'd0, 5'd12, 2'd0, 5'd0, 2'd0);
    check_all("no_valid", 1'b0, 2'd0, 2'd0, 2'd0, 2'd0);

    // Flush during a pending stall.
    do_flush();
    drive_d(1'b1, 5'd0, 2'd0, 5'd0, 2'd0, 5'd8, 2'd2);
    step();
    drive_d(1'b1, 5'd8, 2'd1, 5'd0, 2'd0, 5'd0, 2'd0);
    check("fs_pre_stall", 32'(hz.stall), 32'd1);
    hz.flush = 1'b1;
    step();
    hz.flush = 1'b0;
    #1;
    check_all("fs_post", 1'b0, 2'd0, 2'd0, 2'd0, 2'd0);

    // Reset during a pending stall.
    do_flush();
    drive_d(1'b1, 5'd0, 2'd0, 5'd0, 2'd0, 5'd8, 2'd2);
    step();
    drive_d(1'b1, 5'd8, 2'd1, 5'd0, 2'd0, 5'd0, 2'd0);
    check("rs_pre_stall", 32'(hz.stall), 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
    check_all("rs_post", 1'b0, 2'd0, 2'd0, 2'd0, 2'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Parametrised hazard and forwarding unit for the pipelined MIPS core. Sits beside the D stage. Takes the decoded source addresses (A1/A2), destination address (A3), and Tuse/Tnew timing of the instruction in D. Tracks every in-flight writer across the downstream pipeline stages in a shift-register scoreboard, and produces the D-stage stall plus forward selects for both the D-stage and E-stage operand reads.

## Interface
Parameters:
- ADDR_W, 5: register address width.
- STAGES, 3: number of tracked stages after D (index 0 = E, 1 = M, 2 = W).
- T_W, 2: width of Tuse/Tnew fields.
- FW_W = clog2(STAGES+1): derived width of forward selects (localparam).

Ports:
- clk  in  1  clock. Everything is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- d_valid  in  1  D holds a real instruction.
- d_a1, d_a2  in  ADDR_W  source register addresses; 0 = unused.
- d_tuse1, d_tuse2  in  T_W  cycles from D until each source is consumed.
- d_a3  in  ADDR_W  destination address; 0 = no write.
- d_tnew  in  T_W  cycles from E entry until the result is forwardable.
- flush  in  1  invalidate all scoreboard entries.
- stall  out  1  freeze PC/D register and insert a bubble into E.
- d_fwd1_sel, d_fwd2_sel  out  FW_W  D-read source: 0 = register file; k+1 = stage k.
- e_fwd1_sel, e_fwd2_sel  out  FW_W  E-read source, same encoding.

## Operation
- Entry k holds {valid, a3, tnew}. Entry 0 additionally holds {src1, src2}, the E instruction's source addresses.
- Entry k is "live for addr" when valid, a3 == addr, and addr != 0.
- Every cycle, entries 1..STAGES-1 take entry k-1. Tnew is decremented, saturating at 0. Source fields are not propagated.
- Entry 0 load:
  - reset or flush: valid = 0, src1 = src2 = 0.
  - stall: bubble, with valid = 0 and src1 = src2 = 0.
  - otherwise: valid = d_valid && d_a3 != 0; a3 = d_a3; tnew = d_tnew; src1 = d_a1; src2 = d_a2.
- flush has priority over stall for the entry-0 load. flush clears all entries in the same edge.
- D check, per source i with d_a_i != 0 and d_valid:
  - Select the youngest live entry (lowest k).
  - If its tnew > d_tuse_i: stall = 1.
  - Else if its tnew == 0: d_fwd_i_sel = k+1.
  - Else: d_fwd_i_sel = 0. A later stage forwards.
  - No live entry: d_fwd_i_sel = 0.
- stall = OR of both source checks.
- E check: the same youngest-match search over entries 1..STAGES-1, using entry 0's src_i. Forward only when the matched tnew == 0; otherwise 0. A source of 0 gives 0.
- Older matches behind a younger match are ignored. This holds even when the younger one is not yet ready, so a stale value is never forwarded.

## Timing
- Outputs are combinational from current inputs and scoreboard state, with zero latency.
- State changes only on the clk edge.
- After reset: all entries invalid, so stall = 0 and every fwd_sel = 0 for any input.
- A stall lasts exactly until the blocking entry's tnew has decremented to ≤ Tuse. For a tnew = 2 producer against a Tuse = 1 consumer, that is one bubble.
- reset asserted mid-stall: the next cycle has stall = 0 and the scoreboard is empty. Pending bubbles are discarded.
- A simultaneous flush and stall yields an empty scoreboard.
- The entry in stage STAGES-1 is dropped on the next edge. Its writeback is assumed visible through the register file (internal write-through).

## Test plan
1. Reset: hold reset 2 cycles with d_a1 = 8, d_tuse1 = 0 -> stall = 0 and all fwd_sel = 0 during reset and on the first cycle after.
2. Load-use: a lw with d_a3 = 8, d_tnew = 2 clocks in. D then presents addu with d_a1 = 8, d_tuse1 = 1.
   - Cycle 1: stall = 1.
   - Next edge: entry 0 is a bubble; entry 1 holds tnew = 1. Now stall = 0, d_fwd1_sel = 0.
   - Next edge: e_fwd1_sel = 3.
3. ALU back-to-back: addu with d_a3 = 9, d_tnew = 1 enters E. D presents d_a2 = 9, d_tuse2 = 1.
   - stall = 0.
   - One edge later: e_fwd2_sel = 2 (M).
4. Youngest wins: write r10 with tnew = 1 followed by write r10 with tnew = 2. D reads r10 with Tuse 0 -> stall = 1. The older, ready entry must not be forwarded.
5. $0 immunity: entry live for a3 = 0 is attempted with d_tnew = 3. D reads d_a1 = 0 -> stall = 0, fwd = 0.
6. Flush: assert flush while a stall is pending -> the next cycle has stall = 0 and e_fwd*_sel = 0.
